// File: rtl/i2c_master_writer_if.sv
// Host handshake plus open-drain I2C line signals for the I2C write initiator.
// The master modport is the initiator's view; the slave modport is the host/bus side.
interface i2c_master_writer_if;
    logic        start_i;
    logic [6:0]  slave_addr_i;
    logic [15:0] data_i;
    logic        sda_i;
    logic        scl_i;
    logic        sda_o;
    logic        scl_o;
    logic        busy_o;
    logic        done_o;
    logic        nack_o;

    modport master (
        input  start_i, slave_addr_i, data_i, sda_i, scl_i,
        output sda_o, scl_o, busy_o, done_o, nack_o
    );

    modport slave (
        output start_i, slave_addr_i, data_i, sda_i, scl_i,
        input  sda_o, scl_o, busy_o, done_o, nack_o
    );
endinterface

// File: rtl/i2c_master_writer.sv
// I2C write initiator: START, 7-bit address with W=0, two data bytes MSB-first, ACK check, STOP.
// Open-drain outputs: 1 releases the line, 0 pulls it low.
module i2c_master_writer #(
    parameter  int unsigned CLK_DIV = 125,
    localparam int unsigned QW      = $clog2(CLK_DIV)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    i2c_master_writer_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;

    localparam logic [QW-1:0] CNT_MAX = QW'(CLK_DIV - 1);

    state_t      state;
    logic [1:0]  q;
    logic [QW-1:0] cnt;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] shreg;
    logic        sda_r;
    logic        scl_r;
    logic        busy_r;
    logic        done_r;
    logic        nack_r;
    logic        stall;
    logic        q_end;

    // A slave holding SCL low while we release it freezes the quarter count.
    assign stall = (q == 2'd2) && scl_r && !bus.scl_i;
    assign q_end = (cnt == CNT_MAX) && !stall;

    assign bus.sda_o  = sda_r;
    assign bus.scl_o  = scl_r;
    assign bus.busy_o = busy_r;
    assign bus.done_o = done_r;
    assign bus.nack_o = nack_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= IDLE;
            q        <= '0;
            cnt      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            sda_r    <= 1'b1;
            scl_r    <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            nack_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        shreg    <= {bus.slave_addr_i, 1'b0, bus.data_i};
                        nack_r   <= 1'b0;
                        busy_r   <= 1'b1;
                        state    <= START;
                        q        <= '0;
                        cnt      <= '0;
                        byte_cnt <= '0;
                        sda_r    <= 1'b0;
                        scl_r    <= 1'b1;
                    end
                end

                DONE: state <= IDLE;

                default: begin
                    if (!stall) begin
                        cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
                    end
                    // Outputs are registered, so each branch loads the levels of the next quarter.
                    if (q_end) begin
                        q <= q + 2'd1;
                        case (state)
                            START: begin
                                if (q == 2'd0) begin
                                    scl_r <= 1'b0;
                                end else begin
                                    state   <= BIT;
                                    q       <= '0;
                                    bit_cnt <= 3'd7;
                                    sda_r   <= shreg[23];
                                    scl_r   <= 1'b0;
                                end
                            end

                            BIT: begin
                                if (q == 2'd1) begin
                                    scl_r <= 1'b1;
                                end else if (q == 2'd3) begin
                                    shreg <= {shreg[22:0], 1'b0};
                                    scl_r <= 1'b0;
                                    if (bit_cnt == 3'd0) begin
                                        state <= ACK;
                                        sda_r <= 1'b1;
                                    end else begin
                                        bit_cnt <= bit_cnt - 3'd1;
                                        sda_r   <= shreg[22];
                                    end
                                end
                            end

                            ACK: begin
                                if (q == 2'd1) begin
                                    scl_r <= 1'b1;
                                end else if (q == 2'd2) begin
                                    if (bus.sda_i) begin
                                        nack_r <= 1'b1;
                                    end
                                end else if (q == 2'd3) begin
                                    scl_r <= 1'b0;
                                    if (nack_r || byte_cnt == 2'd2) begin
                                        state <= STOP;
                                        sda_r <= 1'b0;
                                    end else begin
                                        state    <= BIT;
                                        byte_cnt <= byte_cnt + 2'd1;
                                        bit_cnt  <= 3'd7;
                                        sda_r    <= shreg[23];
                                    end
                                end
                            end

                            STOP: begin
                                if (q == 2'd1) begin
                                    scl_r <= 1'b1;
                                end else if (q == 2'd2) begin
                                    sda_r <= 1'b1;
                                end else if (q == 2'd3) begin
                                    state  <= DONE;
                                    busy_r <= 1'b0;
                                    done_r <= 1'b1;
                                end
                            end

                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_writer.sv
// Self-checking bench for i2c_master_writer: a bit-level slave model decodes the wire and
// feeds an observed-byte queue that is compared against bytes queued when each start is driven.
module tb_i2c_master_writer;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned FRAME   = 114 * CLK_DIV;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic sda_pull = 1'b0;
    logic stretch  = 1'b0;

    i2c_master_writer_if bus();

    assign bus.sda_i = bus.sda_o & ~sda_pull;
    assign bus.scl_i = bus.scl_o & ~stretch;

    i2c_master_writer #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    // Slave model state; bit n of ack_plan = 1 means ACK byte n.
    logic [2:0]  ack_plan   = 3'b111;
    logic        prev_scl   = 1'b1;
    logic        prev_sda   = 1'b1;
    logic        in_frame   = 1'b0;
    logic        pulse_high = 1'b0;
    logic        bit_val    = 1'b0;
    logic [7:0]  sh         = '0;
    int unsigned nbits      = 0;
    int unsigned pulses     = 0;
    int unsigned starts     = 0;
    int unsigned stops      = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_frame   = 1'b0;
            pulse_high = 1'b0;
            nbits      = 0;
            sda_pull   = 1'b0;
        end else if (prev_scl && bus.scl_o && prev_sda && !bus.sda_i) begin
            starts++;
            in_frame   = 1'b1;
            nbits      = 0;
            pulse_high = 1'b0;
            sda_pull   = 1'b0;
        end else if (prev_scl && bus.scl_o && !prev_sda && bus.sda_i) begin
            stops++;
            in_frame = 1'b0;
            sda_pull = 1'b0;
        end else if (in_frame) begin
            if (!prev_scl && bus.scl_o) begin
                bit_val    = bus.sda_i;
                pulse_high = 1'b1;
            end
            if (prev_scl && !bus.scl_o) begin
                if (pulse_high) begin
                    pulses++;
                    pulse_high = 1'b0;
                    if (nbits % 9 < 8) begin
                        sh = {sh[6:0], bit_val};
                        if (nbits % 9 == 7) obs_q.push_back(sh);
                    end
                    nbits++;
                end
                sda_pull = (nbits % 9 == 8) && (nbits / 9 < 3) && ack_plan[2'(nbits / 9)];
            end
        end
        prev_scl = bus.scl_o;
        prev_sda = bus.sda_i;
    end

    // Called at a negedge; returns at the negedge of the first cycle after the accept edge.
    task automatic start_frame(input logic [6:0] a, input logic [15:0] d, input logic [2:0] plan);
        ack_plan = plan;
        pulses   = 0;
        starts   = 0;
        stops    = 0;
        exp_q.push_back({a, 1'b0});
        if (plan[0]) begin
            exp_q.push_back(d[15:8]);
            if (plan[1]) exp_q.push_back(d[7:0]);
        end
        bus.slave_addr_i = a;
        bus.data_i       = d;
        bus.start_i      = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // Samples from the current negedge (n=1) until 4 cycles after done_o or the budget expires.
    task automatic watch_frame(input int unsigned budget, output int unsigned busy_cyc,
                               output int unsigned done_cnt, output int unsigned done_at);
        int unsigned tail;
        busy_cyc = 0;
        done_cnt = 0;
        done_at  = 0;
        tail     = 0;
        for (int unsigned n = 1; n <= budget && tail < 4; n++) begin
            if (bus.busy_o) busy_cyc++;
            if (bus.done_o) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (done_at != 0) tail++;
            @(negedge clk);
        end
    endtask

    task automatic stretch_bit3(input int unsigned budget);
        logic prev;
        int unsigned rises;
        prev  = bus.scl_o;
        rises = 0;
        for (int unsigned n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!prev && bus.scl_o) rises++;
            prev = bus.scl_o;
            if (rises == 14) begin
                stretch = 1'b1;
                repeat (20) @(negedge clk);
                stretch = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i      = 1'b0;
        bus.slave_addr_i = '0;
        bus.data_i       = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.sda_o !== 1'b1)  begin n_fail++; $display("FAIL reset_sda: got %b want 1", bus.sda_o); end
        n_checks++; if (bus.scl_o !== 1'b1)  begin n_fail++; $display("FAIL reset_scl: got %b want 1", bus.scl_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
        n_checks++; if (bus.nack_o !== 1'b0) begin n_fail++; $display("FAIL reset_nack: got %b want 0", bus.nack_o); end
    endtask

    task automatic test_full_ack();
        int unsigned bc, dc, da;
        logic [7:0] e, o;
        start_frame(7'h2A, 16'hA55A, 3'b111);
        watch_frame(FRAME + 100, bc, dc, da);
        n_checks++; if (bc != FRAME)     begin n_fail++; $display("FAIL full_busy_cycles: got %0d want %0d", bc, FRAME); end
        n_checks++; if (da != FRAME + 1) begin n_fail++; $display("FAIL full_done_cycle: got %0d want %0d", da, FRAME + 1); end
        n_checks++; if (dc != 1)         begin n_fail++; $display("FAIL full_done_pulses: got %0d want 1", dc); end
        n_checks++; if (bus.nack_o !== 1'b0) begin n_fail++; $display("FAIL full_nack: got %b want 0", bus.nack_o); end
        n_checks++; if (bus.sda_o !== 1'b1 || bus.scl_o !== 1'b1) begin
            n_fail++; $display("FAIL full_idle_lines: got sda=%b scl=%b want 1/1", bus.sda_o, bus.scl_o);
        end
        n_checks++; if (pulses != 27) begin n_fail++; $display("FAIL full_scl_pulses: got %0d want 27", pulses); end
        n_checks++; if (starts != 1 || stops != 1) begin
            n_fail++; $display("FAIL full_sda_while_scl_high: got starts=%0d stops=%0d want 1/1", starts, stops);
        end
        n_checks++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL full_nbytes: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL full_byte: got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_nack_addr();
        int unsigned bc, dc, da;
        logic [7:0] e, o;
        start_frame(7'h51, 16'hBEEF, 3'b000);
        watch_frame(FRAME, bc, dc, da);
        n_checks++; if (bc != 42 * CLK_DIV)     begin n_fail++; $display("FAIL naddr_busy_cycles: got %0d want %0d", bc, 42 * CLK_DIV); end
        n_checks++; if (da != 42 * CLK_DIV + 1) begin n_fail++; $display("FAIL naddr_done_cycle: got %0d want %0d", da, 42 * CLK_DIV + 1); end
        n_checks++; if (pulses != 9) begin n_fail++; $display("FAIL naddr_scl_pulses: got %0d want 9", pulses); end
        n_checks++; if (bus.nack_o !== 1'b1) begin n_fail++; $display("FAIL naddr_nack: got %b want 1", bus.nack_o); end
        n_checks++; if (stops != 1) begin n_fail++; $display("FAIL naddr_stop: got %0d want 1", stops); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL naddr_nbytes: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL naddr_byte: got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_nack_data2();
        int unsigned bc, dc, da;
        logic [7:0] e, o;
        start_frame(7'h3C, 16'h1357, 3'b011);
        watch_frame(FRAME + 100, bc, dc, da);
        n_checks++; if (bc != FRAME)  begin n_fail++; $display("FAIL ndata_busy_cycles: got %0d want %0d", bc, FRAME); end
        n_checks++; if (pulses != 27) begin n_fail++; $display("FAIL ndata_scl_pulses: got %0d want 27", pulses); end
        n_checks++; if (bus.nack_o !== 1'b1) begin n_fail++; $display("FAIL ndata_nack: got %b want 1", bus.nack_o); end
        // Next accepted start must clear the sticky flag on its accept edge.
        start_frame(7'h2A, 16'hFFFF, 3'b111);
        n_checks++; if (bus.nack_o !== 1'b0) begin n_fail++; $display("FAIL ndata_nack_clear: got %b want 0", bus.nack_o); end
        n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL ndata_restart_busy: got %b want 1", bus.busy_o); end
        watch_frame(FRAME + 100, bc, dc, da);
        n_checks++; if (bus.nack_o !== 1'b0) begin n_fail++; $display("FAIL ndata_acked_nack: got %b want 0", bus.nack_o); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ndata_nbytes: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL ndata_byte: got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_stretch();
        int unsigned bc, dc, da;
        logic [7:0] e, o;
        start_frame(7'h2A, 16'hA55A, 3'b111);
        fork
            watch_frame(FRAME + 200, bc, dc, da);
            stretch_bit3(FRAME);
        join
        n_checks++; if (bc != FRAME + 20)     begin n_fail++; $display("FAIL stretch_busy_cycles: got %0d want %0d", bc, FRAME + 20); end
        n_checks++; if (da != FRAME + 21)     begin n_fail++; $display("FAIL stretch_done_cycle: got %0d want %0d", da, FRAME + 21); end
        n_checks++; if (starts != 1 || stops != 1) begin
            n_fail++; $display("FAIL stretch_sda_while_scl_high: got starts=%0d stops=%0d want 1/1", starts, stops);
        end
        n_checks++; if (pulses != 27) begin n_fail++; $display("FAIL stretch_scl_pulses: got %0d want 27", pulses); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL stretch_nbytes: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL stretch_byte: got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        int unsigned bc, dc, da;
        logic [7:0] e, o;
        start_frame(7'h2A, 16'hA55A, 3'b111);
        repeat (44 * CLK_DIV) @(negedge clk);
        n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b want 1", bus.busy_o); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.sda_o !== 1'b1)  begin n_fail++; $display("FAIL rmid_sda: got %b want 1", bus.sda_o); end
        n_checks++; if (bus.scl_o !== 1'b1)  begin n_fail++; $display("FAIL rmid_scl: got %b want 1", bus.scl_o); end
        n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", bus.busy_o); end
        n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b want 0", bus.done_o); end
        rst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        // A start pulse with different operands arrives mid-frame and must be ignored.
        start_frame(7'h13, 16'h1234, 3'b111);
        repeat (40) @(negedge clk);
        bus.slave_addr_i = 7'h7F;
        bus.data_i       = 16'hFFFF;
        bus.start_i      = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL ign_busy: got %b want 1", bus.busy_o); end
        watch_frame(FRAME + 100, bc, dc, da);
        n_checks++; if (da != FRAME + 1 - 41) begin n_fail++; $display("FAIL ign_done_cycle: got %0d want %0d", da, FRAME + 1 - 41); end
        n_checks++; if (dc != 1) begin n_fail++; $display("FAIL ign_done_pulses: got %0d want 1", dc); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ign_nbytes: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL ign_byte: got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int unsigned bc, dc, da;
        logic seen;
        logic [7:0] e, o;
        start_frame(7'h2A, 16'h0F0F, 3'b111);
        seen = 1'b0;
        for (int unsigned n = 0; n < FRAME + 100; n++) begin
            if (bus.done_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b want 1", seen); end
        @(negedge clk);
        n_checks++; if (bus.sda_o !== 1'b1 || bus.scl_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_idle_lines: got sda=%b scl=%b want 1/1", bus.sda_o, bus.scl_o);
        end
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h01);
        bus.slave_addr_i = 7'h55;
        bus.data_i       = 16'h8001;
        bus.start_i      = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", bus.busy_o); end
        n_checks++; if (bus.sda_o !== 1'b0 || bus.scl_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_start_cond: got sda=%b scl=%b want 0/1", bus.sda_o, bus.scl_o);
        end
        watch_frame(FRAME + 100, bc, dc, da);
        n_checks++; if (da != FRAME + 1) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d want %0d", da, FRAME + 1); end
        n_checks++; if (starts != 2 || stops != 2) begin
            n_fail++; $display("FAIL b2b_frames: got starts=%0d stops=%0d want 2/2", starts, stops);
        end
        n_checks++; if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_nbytes: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_byte: got %h want %h", o, e); end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_full_ack();
        test_nack_addr();
        test_nack_data2();
        test_stretch();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
